spi_display_slave: RTL and testbench
====================================

SPI_DISPLAY_SLAVE -- requirements
Module: spi_display_slave

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth for sclk/ss/mosi; legal values 2..3.
REQ-002 Parameter HEADER, default 4'hA: required upper nibble of the command byte.
REQ-003 Port clk, input, 1: single system clock; all state on its rising edge; clk SHALL be at least 8x sclk.
REQ-004 Port rst, input, 1: asynchronous active-low reset.
REQ-005 Port ss, input, 1: SPI slave select, active-low, asynchronous to clk.
REQ-006 Port sclk, input, 1: SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
REQ-007 Port mosi, input, 1: serial data from master, MSB first.
REQ-008 Port miso, output, 1: serial data to master.
REQ-009 Port digits, output, 16: four BCD/hex nibbles, [15:12] leftmost digit.
REQ-010 Port mode, output, 2: display mode from last accepted frame.
REQ-011 Port frame_valid, output, 1: one-cycle pulse on frame acceptance.
REQ-012 Port frame_err, output, 1: one-cycle pulse on frame rejection.
REQ-013 Port busy, output, 1: high while synchronized ss is low.

Function
REQ-014 Frame SHALL be 24 bits within one ss-low window: byte0 = {HEADER, 2'b00, mode}, byte1 = digits[15:8], byte2 = digits[7:0].
REQ-015 sclk, ss and mosi SHALL pass through SYNC_STAGES flops; edges SHALL be detected one cycle later; no raw input drives any flop except a synchronizer.
REQ-016 mosi SHALL be sampled on each synchronized sclk rising edge into a 24-bit shift register, MSB first.
REQ-017 FSM states: IDLE (ss high), SHIFT (ss low, counting bits), CHECK (one cycle after ss rising edge), back to IDLE.
REQ-018 IDLE->SHIFT on synchronized ss falling edge; bit counter and shift register SHALL clear on that edge.
REQ-019 Bit counter SHALL be 5 bits and saturate at 31; wrap-around is forbidden.
REQ-020 SHIFT->CHECK on synchronized ss rising edge; a sclk rising edge in the same cycle SHALL be discarded.
REQ-021 In CHECK, accept iff count == 24 and byte0[7:4] == HEADER and byte0[3:2] == 2'b00.
REQ-022 On accept, digits and mode SHALL load in the CHECK cycle and frame_valid SHALL pulse in the following cycle (3 + SYNC_STAGES clk after raw ss rise).
REQ-023 On reject (short, long or bad header), digits/mode SHALL hold and frame_err SHALL pulse at the same latency.
REQ-024 frame_valid and frame_err SHALL never be high together.
REQ-025 ss falling during CHECK SHALL be honoured: next state SHIFT, counter cleared.
REQ-026 busy SHALL equal the inverted synchronized ss.
REQ-027 Without the echo feature, miso SHALL be constant 0.

Reset
REQ-028 On rst low: state IDLE, digits 16'h0000, mode 2'b00, frame_valid 0, frame_err 0, miso 0, counter 0, synchronizers 1 for ss and 0 for sclk/mosi.
REQ-029 Reset during SHIFT SHALL abort the frame with no frame_valid/frame_err pulse after release.
REQ-030 After rst release with ss already low, the block SHALL stay IDLE until a full ss high->low edge.

Configuration
REQ-031 Macro SPI_DISP_ECHO_EN defined: miso SHALL shift out, MSB first, the previous received byte, updated on synchronized sclk falling edges; during byte0 it SHALL send {frame_count[3:0], 2'b00, last_err, last_valid}.
REQ-032 SPI_DISP_ECHO_EN undefined: echo register, frame_count and status logic SHALL be absent; miso tied 0.

Structure
REQ-033 Package spi_disp_pkg SHALL hold FRAME_BITS = 24, HEADER default, and the FSM state typedef (IDLE, SHIFT, CHECK).
REQ-034 Sub-module spi_sync_edge SHALL implement one synchronizer with rise/fall pulses, instantiated three times.

Verification
REQ-035 Frame A1 32 10 at sclk = clk/8 -> digits 16'h3210, mode 1, one frame_valid, no frame_err.
REQ-036 Frame A2 3A 1B -> digits 16'h3A1B, mode 2; then frame 53 96 58 (bad header) -> frame_err, digits stay 16'h3A1B.
REQ-037 Only 23 bits clocked, then 25 bits -> two frame_err pulses; digits/mode unchanged.
REQ-038 rst low after 12 bits of A3 16 58 -> digits 0, mode 0; no pulse after release; next frame A3 16 58 -> digits 16'h1658, mode 3.
REQ-039 SPI_DISP_ECHO_EN: two frames A0 32 10 -> second frame miso byte0 = 8'h11, byte1 = 8'hA0, byte2 = 8'h32.
REQ-040 Back-to-back frames with ss high for 1 sclk period -> both accepted, two frame_valid pulses.

Source files
------------

// File: rtl/spi_disp_pkg.sv
// Shared constants and FSM state type for the SPI display slave.
package spi_disp_pkg;

   localparam int unsigned FRAME_BITS     = 24;
   localparam logic [3:0]  HEADER_DEFAULT = 4'hA;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      CHECK = 2'd2
   } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with registered rise/fall pulses for one asynchronous input.
module spi_sync_edge #(
   parameter int unsigned STAGES    = 2,
   parameter logic        RESET_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;
   logic [STAGES:0]   primed_q;
   logic              rise_q;
   logic              fall_q;

   // Edges are suppressed until the chain and prev_q hold only post-reset samples,
   // so the reset value never masquerades as an edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q   <= {STAGES{RESET_VAL}};
         prev_q   <= RESET_VAL;
         primed_q <= '0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
      end else begin
         sync_q   <= {sync_q[STAGES-2:0], d_i};
         prev_q   <= sync_q[STAGES-1];
         primed_q <= {primed_q[STAGES-1:0], 1'b1};
         rise_q   <= primed_q[STAGES] &  sync_q[STAGES-1] & ~prev_q;
         fall_q   <= primed_q[STAGES] & ~sync_q[STAGES-1] &  prev_q;
      end
   end

   assign q_o    = sync_q[STAGES-1];
   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/spi_display_slave.sv
// SPI mode-0 slave receiving 24-bit display frames {header,mode,digits}.
// Optional miso echo/status channel enabled by defining SPI_DISP_ECHO_EN.
module spi_display_slave
   import spi_disp_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [3:0]  HEADER      = HEADER_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ss,
   input  logic        sclk,
   input  logic        mosi,
   output logic        miso,
   output logic [15:0] digits,
   output logic [1:0]  mode,
   output logic        frame_valid,
   output logic        frame_err,
   output logic        busy
);

   logic ss_s, ss_rise, ss_fall;
   logic sclk_s, sclk_rise, sclk_fall;
   logic mosi_s, mosi_rise, mosi_fall;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
      .clk_i(clk), .rst_ni(rst), .d_i(ss),
      .q_o(ss_s), .rise_o(ss_rise), .fall_o(ss_fall)
   );
   spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
      .clk_i(clk), .rst_ni(rst), .d_i(sclk),
      .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
   );
   spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
      .clk_i(clk), .rst_ni(rst), .d_i(mosi),
      .q_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall)
   );

   logic unused_sync;
   assign unused_sync = ^{sclk_s, sclk_fall, mosi_rise, mosi_fall};

   state_e                state_q, state_d;
   logic [4:0]            count_q, count_d;
   logic [FRAME_BITS-1:0] shreg_q, shreg_d;
   logic [15:0]           digits_q, digits_d;
   logic [1:0]            mode_q, mode_d;
   logic                  valid_q, valid_d;
   logic                  err_q, err_d;
   logic                  accept;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         count_q  <= '0;
         shreg_q  <= '0;
         digits_q <= '0;
         mode_q   <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         shreg_q  <= shreg_d;
         digits_q <= digits_d;
         mode_q   <= mode_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      shreg_d  = shreg_q;
      digits_d = digits_q;
      mode_d   = mode_q;
      valid_d  = 1'b0;
      err_d    = 1'b0;
      accept   = (count_q == 5'(FRAME_BITS)) &&
                 (shreg_q[FRAME_BITS-1 -: 4] == HEADER) &&
                 (shreg_q[FRAME_BITS-5 -: 2] == 2'b00);
      unique case (state_q)
         IDLE: begin
            if (ss_fall) begin
               state_d = SHIFT;
               count_d = '0;
               shreg_d = '0;
            end
         end
         SHIFT: begin
            // A sclk edge coincident with ss release belongs to no frame.
            if (ss_rise) begin
               state_d = CHECK;
            end else if (sclk_rise) begin
               shreg_d = {shreg_q[FRAME_BITS-2:0], mosi_s};
               if (count_q != '1) count_d = count_q + 5'd1;
            end
         end
         CHECK: begin
            if (accept) begin
               digits_d = shreg_q[15:0];
               mode_d   = shreg_q[FRAME_BITS-7 -: 2];
               valid_d  = 1'b1;
            end else begin
               err_d    = 1'b1;
            end
            if (ss_fall) begin
               state_d = SHIFT;
               count_d = '0;
               shreg_d = '0;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign digits      = digits_q;
   assign mode        = mode_q;
   assign frame_valid = valid_q;
   assign frame_err   = err_q;
   assign busy        = ~ss_s;

`ifdef SPI_DISP_ECHO_EN
   logic [7:0] echo_q;
   logic       skip_q;
   logic [3:0] fcount_q, fcount_d;
   logic       last_err_q, last_err_d;
   logic       last_valid_q, last_valid_d;
   logic       byte_done;

   always_comb begin
      fcount_d     = fcount_q;
      last_err_d   = last_err_q;
      last_valid_d = last_valid_q;
      if (valid_d) begin
         fcount_d     = fcount_q + 4'd1;
         last_valid_d = 1'b1;
         last_err_d   = 1'b0;
      end else if (err_d) begin
         last_valid_d = 1'b0;
         last_err_d   = 1'b1;
      end
   end

   assign byte_done = (state_q == SHIFT) && !ss_rise && sclk_rise && (count_d[2:0] == 3'd0);

   // The falling edge right after a byte reload must not shift, so the new MSB stays on miso.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         echo_q       <= '0;
         skip_q       <= 1'b0;
         fcount_q     <= '0;
         last_err_q   <= 1'b0;
         last_valid_q <= 1'b0;
      end else begin
         fcount_q     <= fcount_d;
         last_err_q   <= last_err_d;
         last_valid_q <= last_valid_d;
         if ((state_d == SHIFT) && (state_q != SHIFT)) begin
            echo_q <= {fcount_d, 2'b00, last_err_d, last_valid_d};
            skip_q <= 1'b0;
         end else if (byte_done) begin
            echo_q <= shreg_d[7:0];
            skip_q <= 1'b1;
         end else if (sclk_fall && (state_q == SHIFT)) begin
            if (skip_q) skip_q <= 1'b0;
            else        echo_q <= {echo_q[6:0], 1'b0};
         end
      end
   end

   assign miso = echo_q[7];
`else
   assign miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_display_slave.sv
// Randomized self-checking bench for spi_display_slave against a frame-level reference model.
module tb_spi_display_slave;

   localparam int unsigned SYNC = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        ss;
   logic        sclk;
   logic        mosi;
   logic        miso;
   logic [15:0] digits;
   logic [1:0]  mode;
   logic        frame_valid;
   logic        frame_err;
   logic        busy;

   int unsigned total = 0;
   int unsigned bad   = 0;
   int unsigned n_valid = 0;
   int unsigned n_err   = 0;
   int unsigned both_cnt = 0;
   int unsigned half = 4;
   logic [31:0] rx_miso = '0;

   logic [15:0] exp_digits = '0;
   logic [1:0]  exp_mode   = '0;
   bit          exp_ok;

   spi_display_slave #(.SYNC_STAGES(SYNC), .HEADER(4'hA)) dut (
      .clk(clk), .rst(rst), .ss(ss), .sclk(sclk), .mosi(mosi), .miso(miso),
      .digits(digits), .mode(mode), .frame_valid(frame_valid),
      .frame_err(frame_err), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst) begin
         if (frame_valid) n_valid++;
         if (frame_err) n_err++;
         if (frame_valid && frame_err) both_cnt++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Frame-level rule: exactly 24 bits, header nibble A, reserved bits zero.
   function automatic void model_frame(input logic [31:0] data, input int unsigned nbits);
      logic [23:0] f;
      f = data[23:0];
      exp_ok = (nbits == 24) && (f[23:20] == 4'hA) && (f[19:18] == 2'b00);
      if (exp_ok) begin
         exp_digits = f[15:0];
         exp_mode   = f[17:16];
      end
   endfunction

   task automatic spi_send(input logic [31:0] data, input int unsigned nbits, input bit release_ss);
      ss = 1'b0;
      for (int unsigned k = 0; k < nbits; k++) begin
         mosi = data[nbits-1-k];
         repeat (half) @(negedge clk);
         rx_miso = {rx_miso[30:0], miso};
         sclk = 1'b1;
         repeat (half) @(negedge clk);
         sclk = 1'b0;
      end
      repeat (half) @(negedge clk);
      if (release_ss) ss = 1'b1;
   endtask

   task automatic run_frame(input logic [31:0] data, input int unsigned nbits,
                            output int unsigned dv, output int unsigned de, output int unsigned lat);
      int unsigned v0, e0;
      v0 = n_valid;
      e0 = n_err;
      lat = 0;
      spi_send(data, nbits, 1'b1);
      for (int unsigned k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (lat == 0 && (frame_valid || frame_err)) lat = k;
      end
      dv = n_valid - v0;
      de = n_err - e0;
   endtask

   task automatic test_reset;
      rst = 1'b0; ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (digits !== 16'h0000) begin bad++; $display("FAIL reset_digits got=%h exp=0000", digits); end
      total++; if (mode !== 2'b00) begin bad++; $display("FAIL reset_mode got=%0d exp=0", mode); end
      total++; if (frame_valid !== 1'b0 || frame_err !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%b%b exp=00", frame_valid, frame_err); end
      total++; if (miso !== 1'b0) begin bad++; $display("FAIL reset_miso got=%b exp=0", miso); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      rst = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic test_frame;
      int unsigned dv, de, lat;
      model_frame(32'hA13210, 24);
      spi_send(32'hA13210, 24, 1'b0);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_in_frame got=%b exp=1", busy); end
      ss = 1'b1;
      lat = 0;
      for (int unsigned k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (lat == 0 && frame_valid) lat = k;
      end
      total++; if (lat !== 3 + SYNC) begin bad++; $display("FAIL frame_latency got=%0d exp=%0d", lat, 3 + SYNC); end
      total++; if (digits !== 16'h3210 || digits !== exp_digits) begin bad++; $display("FAIL frame_digits got=%h exp=3210", digits); end
      total++; if (mode !== 2'd1) begin bad++; $display("FAIL frame_mode got=%0d exp=1", mode); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_idle got=%b exp=0", busy); end
      run_frame(32'hA23A1B, 24, dv, de, lat);
      model_frame(32'hA23A1B, 24);
      total++; if (dv !== 1 || de !== 0) begin bad++; $display("FAIL frame2_pulses got=v%0d/e%0d exp=v1/e0", dv, de); end
      total++; if (digits !== exp_digits || mode !== exp_mode) begin bad++; $display("FAIL frame2_out got=%h/%0d exp=%h/%0d", digits, mode, exp_digits, exp_mode); end
   endtask

   task automatic test_bad_header;
      int unsigned dv, de, lat;
      run_frame(32'h539658, 24, dv, de, lat);
      model_frame(32'h539658, 24);
      total++; if (dv !== 0 || de !== 1) begin bad++; $display("FAIL badhdr_pulses got=v%0d/e%0d exp=v0/e1", dv, de); end
      total++; if (lat !== 3 + SYNC) begin bad++; $display("FAIL badhdr_latency got=%0d exp=%0d", lat, 3 + SYNC); end
      total++; if (digits !== 16'h3A1B || mode !== 2'd2) begin bad++; $display("FAIL badhdr_hold got=%h/%0d exp=3a1b/2", digits, mode); end
   endtask

   task automatic test_length;
      int unsigned dv, de, lat;
      run_frame(32'hA13210 >> 1, 23, dv, de, lat);
      total++; if (dv !== 0 || de !== 1) begin bad++; $display("FAIL short_pulses got=v%0d/e%0d exp=v0/e1", dv, de); end
      run_frame({7'd0, 24'hA13210, 1'b1}, 25, dv, de, lat);
      total++; if (dv !== 0 || de !== 1) begin bad++; $display("FAIL long_pulses got=v%0d/e%0d exp=v0/e1", dv, de); end
      total++; if (digits !== exp_digits || mode !== exp_mode) begin bad++; $display("FAIL length_hold got=%h/%0d exp=%h/%0d", digits, mode, exp_digits, exp_mode); end
   endtask

   task automatic test_reset_abort;
      int unsigned dv, de, lat, v0, e0;
      spi_send(32'hA31, 12, 1'b0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      exp_digits = '0;
      exp_mode   = '0;
      total++; if (digits !== 16'h0000 || mode !== 2'b00) begin bad++; $display("FAIL abort_clear got=%h/%0d exp=0000/0", digits, mode); end
      rst = 1'b1;
      v0 = n_valid; e0 = n_err;
      repeat (4) @(negedge clk);
      ss = 1'b1;
      repeat (30) @(negedge clk);
      total++; if (n_valid !== v0 || n_err !== e0) begin bad++; $display("FAIL abort_nopulse got=v%0d/e%0d exp=v0/e0", n_valid - v0, n_err - e0); end
      run_frame(32'hA31658, 24, dv, de, lat);
      model_frame(32'hA31658, 24);
      total++; if (dv !== 1 || digits !== 16'h1658 || mode !== 2'd3) begin bad++; $display("FAIL abort_next got=%h/%0d v%0d exp=1658/3 v1", digits, mode, dv); end
   endtask

   task automatic test_ss_low_at_reset;
      int unsigned v0, e0;
      ss = 1'b0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      exp_digits = '0;
      exp_mode   = '0;
      repeat (10) @(negedge clk);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL sslow_busy got=%b exp=1", busy); end
      v0 = n_valid; e0 = n_err;
      spi_send(32'hA13210, 24, 1'b1);
      repeat (30) @(negedge clk);
      total++; if (n_valid !== v0 || n_err !== e0 || digits !== 16'h0000) begin bad++; $display("FAIL sslow_idle got=v%0d/e%0d %h exp=v0/e0 0000", n_valid - v0, n_err - e0, digits); end
   endtask

   task automatic test_random;
      int unsigned dv, de, lat, nbits, r;
      logic [31:0] data;
      for (int unsigned i = 0; i < 16; i++) begin
         r = $urandom_range(0, 5);
         nbits = (r == 0) ? 23 : (r == 1) ? 25 : 24;
         data = $urandom;
         data[23:20] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hA;
         data[19:18] = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b00;
         if (nbits == 25) data = {data[30:0], 1'($urandom)};
         model_frame(nbits == 25 ? data >> 1 : data, nbits);
         run_frame(data, nbits, dv, de, lat);
         total++; if (dv !== (exp_ok ? 1 : 0) || de !== (exp_ok ? 0 : 1)) begin bad++; $display("FAIL rand%0d_pulses got=v%0d/e%0d exp_ok=%0d", i, dv, de, exp_ok); end
         total++; if (digits !== exp_digits || mode !== exp_mode) begin bad++; $display("FAIL rand%0d_out got=%h/%0d exp=%h/%0d", i, digits, mode, exp_digits, exp_mode); end
      end
   endtask

   task automatic test_back_to_back;
      int unsigned v0, e0;
      v0 = n_valid; e0 = n_err;
      spi_send(32'hA04321, 24, 1'b1);
      repeat (2 * half) @(negedge clk);
      spi_send(32'hA28765, 24, 1'b1);
      repeat (30) @(negedge clk);
      model_frame(32'hA28765, 24);
      total++; if (n_valid - v0 !== 2 || n_err - e0 !== 0) begin bad++; $display("FAIL b2b_pulses got=v%0d/e%0d exp=v2/e0", n_valid - v0, n_err - e0); end
      total++; if (digits !== exp_digits || mode !== exp_mode) begin bad++; $display("FAIL b2b_out got=%h/%0d exp=%h/%0d", digits, mode, exp_digits, exp_mode); end
   endtask

`ifdef SPI_DISP_ECHO_EN
   task automatic test_echo;
      int unsigned dv, de, lat;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (6) @(negedge clk);
      half = 8;
      run_frame(32'hA03210, 24, dv, de, lat);
      run_frame(32'hA03210, 24, dv, de, lat);
      model_frame(32'hA03210, 24);
      half = 4;
      total++; if (rx_miso[23:16] !== 8'h11) begin bad++; $display("FAIL echo_b0 got=%h exp=11", rx_miso[23:16]); end
      total++; if (rx_miso[15:8] !== 8'hA0) begin bad++; $display("FAIL echo_b1 got=%h exp=a0", rx_miso[15:8]); end
      total++; if (rx_miso[7:0] !== 8'h32) begin bad++; $display("FAIL echo_b2 got=%h exp=32", rx_miso[7:0]); end
   endtask
`else
   task automatic test_echo;
      int unsigned dv, de, lat;
      run_frame(32'hA0FFFF, 24, dv, de, lat);
      model_frame(32'hA0FFFF, 24);
      total++; if (rx_miso[23:0] !== 24'h0) begin bad++; $display("FAIL miso_zero got=%h exp=000000", rx_miso[23:0]); end
   endtask
`endif

   task automatic test_exclusive;
      total++; if (both_cnt !== 0) begin bad++; $display("FAIL valid_err_overlap got=%0d exp=0", both_cnt); end
   endtask

   initial begin
      test_reset;
      test_frame;
      test_bad_header;
      test_length;
      test_reset_abort;
      test_ss_low_at_reset;
      test_random;
      test_back_to_back;
      test_echo;
      test_exclusive;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
